udp_echo_responder: RTL and testbench
=====================================

Name: udp_echo_responder

Overview:
- ROLE-side responder for the NRC UDP path.
- Accepts one inbound datagram as a meta word plus payload beats from NRC, and returns it to the sender with a rewritten meta header.
- Decouples RX payload from TX back-pressure with a payload FIFO.
- Used as the default Themisto application and for loopback bring-up.

Parameters:
- FIFO_DEPTH, 16, payload FIFO depth in 64-bit beats; must be a power of 2 and at least 4.
- RX_PORT_MASK, 32'h0000_0001, value driven on poROL_Nrc_Udp_Rx_ports (open-port vector).

Ports:
- piSHL_156_25Clk  in  1  sole clock.
- piSHL_156_25Rst_n  in  1  asynchronous, active-low reset.
- piMMIO_Ly7_En  in  1  enable; when low, no new datagram is accepted.
- piFMC_ROLE_rank  in  32  own node rank; bits [7:0] are used.
- siNRC_Role_Udp_Meta_TDATA/TVALID/TREADY/TKEEP/TLAST  in/in/out/in/in  80/1/1/10/1  RX meta.
- siNRC_Udp_Data_tdata/tkeep/tvalid/tlast/tready  in/in/in/in/out  64/8/1/1/1  RX payload.
- soROLE_Nrc_Udp_Meta_TDATA/TVALID/TREADY/TKEEP/TLAST  out/out/in/out/out  80/1/1/10/1  TX meta.
- soNRC_Udp_Data_tdata/tkeep/tvalid/tlast/tready  out/out/out/out/in  64/8/1/1/1  TX payload.
- poROL_Nrc_Udp_Rx_ports  out  32  equals RX_PORT_MASK.

Behaviour:
- Meta layout, both directions:
  - [7:0] dst_rank
  - [23:8] dst_port
  - [31:24] src_rank
  - [47:32] src_port
  - [63:48] len in bytes
  - [79:64] reserved, driven 0
- Reset values:
  - all TVALID/tvalid outputs and all TREADY/tready outputs = 0
  - TDATA/tdata/tkeep = 0
  - FIFO empty, FSM in S_IDLE
- RX meta:
  - siNRC_Role_Udp_Meta_TREADY = (state==S_IDLE) & piMMIO_Ly7_En & ~rx_busy.
  - On handshake, the meta word is registered and rx_busy is set.
  - Input TKEEP/TLAST are ignored.
- RX data:
  - tready = rx_busy & ~fifo_full.
  - Each handshaken beat (tdata, tkeep, tlast) is pushed into the FIFO.
  - rx_busy clears on the tlast handshake.
  - Beats arriving while rx_busy=0 are not accepted; tready stays 0.
- FSM:
  - S_IDLE -> S_META, one cycle after the RX meta handshake.
  - S_META:
    - TX meta TVALID=1, TKEEP=10'h3FF, TLAST=1.
    - Output meta: dst_rank=in.src_rank, dst_port=in.src_port, src_rank=piFMC_ROLE_rank[7:0], src_port=in.dst_port, len=in.len.
    - On TREADY -> S_DATA.
  - S_DATA:
    - Pops the FIFO onto the TX data port through an output register.
    - tvalid is held until tready (AXIS rule: data is stable while valid & ~ready).
    - On the TX tlast handshake -> S_IDLE.
- Latency: RX meta handshake to TX meta TVALID = 2 cycles. First RX beat to first TX beat = 2 cycles, given TREADY is already high.
- Throughput: 1 beat/cycle in S_DATA with no back-pressure.
- FIFO full: RX tready drops in the same cycle that fifo_count reaches FIFO_DEPTH. A simultaneous push and pop when full is allowed only through the ready gating, so no beat is lost.
- FIFO empty in S_DATA: tvalid=0 and no pop occurs.
- Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
- Enable deassert mid-datagram: the current datagram completes, and no new meta is accepted afterwards.
- Reset assert at any point: the FSM and FIFO clear immediately (async), and the partial datagram is discarded.
- The len field is passed through and not checked; tlast defines the frame end.

Optional Feature:
- Macro: UDP_ECHO_STATS_EN.
- When defined:
  - Adds output poEcho_Stats[31:0] = {rx_dgram_cnt[15:0], tx_dgram_cnt[15:0]}.
  - Counters increment on the RX tlast handshake and the TX tlast handshake respectively.
  - Counters wrap at 16'hFFFF -> 0 and reset to 0.
- When undefined: the port and the counters are absent.

Decomposition:
- Package udp_echo_pkg contains:
  - the meta field offset/width localparams
  - the state enum (S_IDLE, S_META, S_DATA)
  - the FIFO entry typedef (73 bits: data, keep, last)
- Sub-module udp_echo_fifo: synchronous FIFO with async active-low reset and full/empty/count outputs.

Test Plan:
- Single datagram:
  - Stimulus: meta {len=16, src_port=0x2710, src_rank=3, dst_port=0x2263, dst_rank=1}, rank=1, 2 beats, second beat tkeep=0xFF with tlast.
  - Expected: TX meta {dst_rank=3, dst_port=0x2710, src_rank=1, src_port=0x2263, len=16}, the same 2 beats, meta TVALID 2 cycles after the RX meta handshake.
- Back-pressure:
  - Stimulus: TX meta TREADY=0 for 30 cycles, 24-beat payload, FIFO_DEPTH=16.
  - Expected: RX tready drops after 16 beats; all 24 beats emerge in order once TREADY rises.
- Partial keep:
  - Stimulus: last beat tkeep=0x0F.
  - Expected: TX last beat tkeep=0x0F, tlast=1.
- Enable low:
  - Stimulus: piMMIO_Ly7_En=0 before meta.
  - Expected: meta TREADY stays 0. Stimulus: deassert En mid-datagram. Expected: the datagram completes and the next meta is refused.
- Reset mid-datagram:
  - Stimulus: Rst_n pulse low after 3 of 8 beats.
  - Expected: all valids and readies are 0 immediately; the next datagram echoes cleanly with no stale beats.
- With UDP_ECHO_STATS_EN:
  - Stimulus: 3 datagrams.
  - Expected: poEcho_Stats = 32'h0003_0003.

Source files
------------

// File: rtl/udp_echo_pkg.sv
// -----------------------------------------------------------------------------
// udp_echo_pkg
// Shared definitions for the UDP echo responder:
//   - bit layout of the 80-bit NRC UDP meta word (same in both directions)
//   - the responder FSM state type
//   - the payload FIFO entry type (64-bit data, 8-bit keep, last flag)
//   - buildEchoMeta(): turns an inbound meta into the outbound reply meta
// -----------------------------------------------------------------------------
package udp_echo_pkg;

    localparam int META_W       = 80;
    localparam int META_USED_W  = 64;   // bits above this are reserved
    localparam int RANK_W       = 8;
    localparam int PORT_W       = 16;
    localparam int LEN_W        = 16;

    localparam int DST_RANK_LSB = 0;
    localparam int DST_PORT_LSB = 8;
    localparam int SRC_RANK_LSB = 24;
    localparam int SRC_PORT_LSB = 32;
    localparam int LEN_LSB      = 48;

    localparam int DATA_W       = 64;
    localparam int KEEP_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_META = 2'd1,
        S_DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } fifo_entry_t;

    // Reply goes back to whoever sent the datagram: source and destination
    // swap, our own rank becomes the source rank, length is passed through
    // and the reserved upper bits stay zero.
    function automatic logic [META_W-1:0] buildEchoMeta(
        input logic [META_USED_W-1:0] inMeta,
        input logic [RANK_W-1:0]      ownRank
    );
        logic [META_W-1:0] m;
        m = '0;
        m[DST_RANK_LSB +: RANK_W] = inMeta[SRC_RANK_LSB +: RANK_W];
        m[DST_PORT_LSB +: PORT_W] = inMeta[SRC_PORT_LSB +: PORT_W];
        m[SRC_RANK_LSB +: RANK_W] = ownRank;
        m[SRC_PORT_LSB +: PORT_W] = inMeta[DST_PORT_LSB +: PORT_W];
        m[LEN_LSB      +: LEN_W]  = inMeta[LEN_LSB      +: LEN_W];
        return m;
    endfunction

endpackage

// File: rtl/udp_echo_fifo.sv
// -----------------------------------------------------------------------------
// udp_echo_fifo
// Synchronous first-word-fall-through FIFO for payload beats.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   pushEn       : write pushEntry (ignored while full)
//   popEn        : advance read pointer (ignored while empty)
//   popEntry     : entry at the head, valid whenever empty=0
//   full, empty  : status flags derived from the occupancy count
//   count        : occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module udp_echo_fifo
    import udp_echo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pushEn,
    input  fifo_entry_t              pushEntry,
    input  logic                     popEn,
    output fifo_entry_t              popEntry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign doPush   = pushEn & ~full;
    assign doPop    = popEn & ~empty;
    assign popEntry = mem[rdPtr];

    // Storage is not reset: contents are only ever read behind the count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/udp_echo_responder.sv
// -----------------------------------------------------------------------------
// udp_echo_responder
// Accepts one UDP datagram (meta word + payload beats) from NRC and sends it
// straight back to its sender with a rewritten meta header. Payload is
// buffered in a FIFO so RX is not stalled by TX back-pressure until full.
//
// Ports:
//   piSHL_156_25Clk / piSHL_156_25Rst_n : clock, async active-low reset
//   piMMIO_Ly7_En                       : when low no new datagram starts
//   piFMC_ROLE_rank                     : own rank, [7:0] used
//   siNRC_Role_Udp_Meta_*               : RX meta stream (80-bit)
//   siNRC_Udp_Data_*                    : RX payload stream (64-bit)
//   soROLE_Nrc_Udp_Meta_*               : TX meta stream (80-bit)
//   soNRC_Udp_Data_*                    : TX payload stream (64-bit)
//   poROL_Nrc_Udp_Rx_ports              : open-port vector (RX_PORT_MASK)
//   poDbg_State                         : current FSM state
//   poEcho_Stats                        : {rx, tx} datagram counters, only
//                                         when UDP_ECHO_STATS_EN is defined
//
// Handshake: every stream transfers a word on a clock edge where VALID and
// READY are both high; a source holds VALID and its payload stable until
// that edge, and READY may depend on the sink's state only.
// -----------------------------------------------------------------------------
module udp_echo_responder
    import udp_echo_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] RX_PORT_MASK = 32'h0000_0001
) (
    input  logic        piSHL_156_25Clk,
    input  logic        piSHL_156_25Rst_n,
    input  logic        piMMIO_Ly7_En,
    input  logic [31:0] piFMC_ROLE_rank,

    input  logic [79:0] siNRC_Role_Udp_Meta_TDATA,
    input  logic        siNRC_Role_Udp_Meta_TVALID,
    output logic        siNRC_Role_Udp_Meta_TREADY,
    input  logic [9:0]  siNRC_Role_Udp_Meta_TKEEP,
    input  logic        siNRC_Role_Udp_Meta_TLAST,

    input  logic [63:0] siNRC_Udp_Data_tdata,
    input  logic [7:0]  siNRC_Udp_Data_tkeep,
    input  logic        siNRC_Udp_Data_tvalid,
    input  logic        siNRC_Udp_Data_tlast,
    output logic        siNRC_Udp_Data_tready,

    output logic [79:0] soROLE_Nrc_Udp_Meta_TDATA,
    output logic        soROLE_Nrc_Udp_Meta_TVALID,
    input  logic        soROLE_Nrc_Udp_Meta_TREADY,
    output logic [9:0]  soROLE_Nrc_Udp_Meta_TKEEP,
    output logic        soROLE_Nrc_Udp_Meta_TLAST,

    output logic [63:0] soNRC_Udp_Data_tdata,
    output logic [7:0]  soNRC_Udp_Data_tkeep,
    output logic        soNRC_Udp_Data_tvalid,
    output logic        soNRC_Udp_Data_tlast,
    input  logic        soNRC_Udp_Data_tready,

    output logic [31:0] poROL_Nrc_Udp_Rx_ports,
    output logic [1:0]  poDbg_State
`ifdef UDP_ECHO_STATS_EN
    ,
    output logic [31:0] poEcho_Stats
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------- state
    state_t          state;
    logic            runEn;       // low while in reset, keeps READYs at 0
    logic            rxBusy;      // meta taken, payload still arriving
    logic            metaHs;      // RX meta handshake happened last cycle
    logic [63:0]     rxMeta;

    logic            txMetaValid;
    logic [79:0]     txMetaData;
    logic [9:0]      txMetaKeep;
    logic            txMetaLast;

    logic            txValid;
    fifo_entry_t     txBeat;
    logic            lastLoaded;  // tlast beat already sits in txBeat

    // ------------------------------------------------------------- handshakes
    logic            metaReady;
    logic            dataReady;
    logic            rxMetaHs;
    logic            rxDataHs;
    logic            txMetaHs;
    logic            txDataHs;
    logic            popEn;

    fifo_entry_t     pushEntry;
    fifo_entry_t     fifoHead;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [CW-1:0]   fifoCount;
    logic            unusedBits;

    assign metaReady = runEn & (state == S_IDLE) & piMMIO_Ly7_En & ~rxBusy;
    assign dataReady = rxBusy & ~fifoFull;
    assign rxMetaHs  = siNRC_Role_Udp_Meta_TVALID & metaReady;
    assign rxDataHs  = siNRC_Udp_Data_tvalid & dataReady;
    assign txMetaHs  = txMetaValid & soROLE_Nrc_Udp_Meta_TREADY;
    assign txDataHs  = txValid & soNRC_Udp_Data_tready;

    // Refill the output register when it is empty or being drained, but never
    // past the tlast beat of the current datagram.
    assign popEn = (state == S_DATA) & ~fifoEmpty & ~lastLoaded &
                   (~txValid | soNRC_Udp_Data_tready);

    assign pushEntry = '{data: siNRC_Udp_Data_tdata,
                         keep: siNRC_Udp_Data_tkeep,
                         last: siNRC_Udp_Data_tlast};

    // Input meta TKEEP/TLAST, reserved meta bits and upper rank bits carry no
    // information for this block.
    assign unusedBits = ^{siNRC_Role_Udp_Meta_TDATA[79:64],
                          siNRC_Role_Udp_Meta_TKEEP,
                          siNRC_Role_Udp_Meta_TLAST,
                          piFMC_ROLE_rank[31:8],
                          fifoCount};

    // ---------------------------------------------------------------- RX side
    always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
        if (!piSHL_156_25Rst_n) begin
            runEn  <= 1'b0;
            rxBusy <= 1'b0;
            metaHs <= 1'b0;
            rxMeta <= '0;
        end else begin
            runEn  <= 1'b1;
            metaHs <= rxMetaHs;
            if (rxMetaHs) begin
                rxMeta <= siNRC_Role_Udp_Meta_TDATA[63:0];
                rxBusy <= 1'b1;
            end else if (rxDataHs && siNRC_Udp_Data_tlast) begin
                rxBusy <= 1'b0;
            end
        end
    end

    udp_echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (piSHL_156_25Clk),
        .rst_n     (piSHL_156_25Rst_n),
        .pushEn    (rxDataHs),
        .pushEntry (pushEntry),
        .popEn     (popEn),
        .popEntry  (fifoHead),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (fifoCount)
    );

    // ---------------------------------------------------------------- TX FSM
    always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
        if (!piSHL_156_25Rst_n) begin
            state       <= S_IDLE;
            txMetaValid <= 1'b0;
            txMetaData  <= '0;
            txMetaKeep  <= '0;
            txMetaLast  <= 1'b0;
            txValid     <= 1'b0;
            txBeat      <= '0;
            lastLoaded  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (metaHs) begin
                        state       <= S_META;
                        txMetaValid <= 1'b1;
                        txMetaData  <= buildEchoMeta(rxMeta, piFMC_ROLE_rank[7:0]);
                        txMetaKeep  <= 10'h3FF;
                        txMetaLast  <= 1'b1;
                    end
                end
                S_META: begin
                    if (txMetaHs) begin
                        state       <= S_DATA;
                        txMetaValid <= 1'b0;
                        txMetaKeep  <= '0;
                        txMetaLast  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (popEn) begin
                        txValid    <= 1'b1;
                        txBeat     <= fifoHead;
                        lastLoaded <= fifoHead.last;
                    end else if (txDataHs) begin
                        txValid <= 1'b0;
                    end
                    if (txDataHs && txBeat.last) begin
                        state      <= S_IDLE;
                        lastLoaded <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign siNRC_Role_Udp_Meta_TREADY = metaReady;
    assign siNRC_Udp_Data_tready      = dataReady;

    assign soROLE_Nrc_Udp_Meta_TDATA  = txMetaData;
    assign soROLE_Nrc_Udp_Meta_TVALID = txMetaValid;
    assign soROLE_Nrc_Udp_Meta_TKEEP  = txMetaKeep;
    assign soROLE_Nrc_Udp_Meta_TLAST  = txMetaLast;

    assign soNRC_Udp_Data_tdata       = txBeat.data;
    assign soNRC_Udp_Data_tkeep       = txBeat.keep;
    assign soNRC_Udp_Data_tlast       = txBeat.last;
    assign soNRC_Udp_Data_tvalid      = txValid;

    assign poROL_Nrc_Udp_Rx_ports     = RX_PORT_MASK;
    assign poDbg_State                = state;

`ifdef UDP_ECHO_STATS_EN
    logic [15:0] rxDgramCnt;
    logic [15:0] txDgramCnt;

    always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
        if (!piSHL_156_25Rst_n) begin
            rxDgramCnt <= '0;
            txDgramCnt <= '0;
        end else begin
            if (rxDataHs && siNRC_Udp_Data_tlast) begin
                rxDgramCnt <= rxDgramCnt + 16'd1;
            end
            if (txDataHs && txBeat.last) begin
                txDgramCnt <= txDgramCnt + 16'd1;
            end
        end
    end

    assign poEcho_Stats = {rxDgramCnt, txDgramCnt};
`endif

endmodule

// File: tb/tb_udp_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_udp_echo_responder
// Drives datagrams into udp_echo_responder and checks the echoed meta and
// payload against a reference built from the reply rules (field swap, own
// rank, payload unchanged and in order). Define UDP_ECHO_STATS_EN to also
// check the datagram counters.
// -----------------------------------------------------------------------------
module tb_udp_echo_responder;

    localparam int TMO = 3000;

    // ------------------------------------------------------ clock and reset
    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- DUT I/O
    logic        en;
    logic [31:0] rank;
    logic [79:0] rxMetaData;
    logic        rxMetaValid;
    logic        rxMetaReady;
    logic [9:0]  rxMetaKeep;
    logic        rxMetaLast;
    logic [63:0] rxData;
    logic [7:0]  rxKeep;
    logic        rxValid;
    logic        rxLast;
    logic        rxReady;
    logic [79:0] txMetaData;
    logic        txMetaValid;
    logic        txMetaReady;
    logic [9:0]  txMetaKeep;
    logic        txMetaLast;
    logic [63:0] txData;
    logic [7:0]  txKeep;
    logic        txValid;
    logic        txLast;
    logic        txReady;
    logic [31:0] rxPorts;
    logic [1:0]  dbgState;
`ifdef UDP_ECHO_STATS_EN
    logic [31:0] echoStats;
`endif

    udp_echo_responder dut (
        .piSHL_156_25Clk            (clk),
        .piSHL_156_25Rst_n          (rstN),
        .piMMIO_Ly7_En              (en),
        .piFMC_ROLE_rank            (rank),
        .siNRC_Role_Udp_Meta_TDATA  (rxMetaData),
        .siNRC_Role_Udp_Meta_TVALID (rxMetaValid),
        .siNRC_Role_Udp_Meta_TREADY (rxMetaReady),
        .siNRC_Role_Udp_Meta_TKEEP  (rxMetaKeep),
        .siNRC_Role_Udp_Meta_TLAST  (rxMetaLast),
        .siNRC_Udp_Data_tdata       (rxData),
        .siNRC_Udp_Data_tkeep       (rxKeep),
        .siNRC_Udp_Data_tvalid      (rxValid),
        .siNRC_Udp_Data_tlast       (rxLast),
        .siNRC_Udp_Data_tready      (rxReady),
        .soROLE_Nrc_Udp_Meta_TDATA  (txMetaData),
        .soROLE_Nrc_Udp_Meta_TVALID (txMetaValid),
        .soROLE_Nrc_Udp_Meta_TREADY (txMetaReady),
        .soROLE_Nrc_Udp_Meta_TKEEP  (txMetaKeep),
        .soROLE_Nrc_Udp_Meta_TLAST  (txMetaLast),
        .soNRC_Udp_Data_tdata       (txData),
        .soNRC_Udp_Data_tkeep       (txKeep),
        .soNRC_Udp_Data_tvalid      (txValid),
        .soNRC_Udp_Data_tlast       (txLast),
        .soNRC_Udp_Data_tready      (txReady),
        .poROL_Nrc_Udp_Rx_ports     (rxPorts),
        .poDbg_State                (dbgState)
`ifdef UDP_ECHO_STATS_EN
        ,
        .poEcho_Stats               (echoStats)
`endif
    );

    // ------------------------------------------------------------ scoreboard
    int          total = 0;
    int          bad   = 0;
    logic [72:0] expQ[$];       // {data, keep, last} in expected TX order
    logic [79:0] expMetaQ[$];
    int          accCnt = 0;    // RX beats accepted in the current step
    int          dgDone = 0;    // complete datagrams since last reset
    logic        metaHold = 1'b0;
    logic        randMode = 1'b0;
    logic [7:0]  lastTxKeep = '0;
    logic        lastTxLast = 1'b0;
    logic        prevStall = 1'b0;
    logic [73:0] prevBeat = '0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkTrue(input string tag, input logic cond);
        total++;
        assert (cond === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%b expected=1", tag, cond);
        end
    endtask

    // Reply meta from the datagram rules: sender becomes destination, our
    // rank becomes source rank, original destination port becomes source port.
    function automatic logic [79:0] expEcho(input logic [79:0] m, input logic [31:0] rk);
        logic [15:0] len;
        logic [15:0] sPort;
        logic [15:0] dPort;
        logic [7:0]  sRank;
        len   = m[63:48];
        sPort = m[47:32];
        sRank = m[31:24];
        dPort = m[23:8];
        return {16'h0000, len, dPort, rk[7:0], sPort, sRank};
    endfunction

    // TX sinks: ready patterns for the meta and payload outputs.
    initial begin
        txMetaReady = 1'b0;
        txReady     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            txMetaReady = metaHold ? 1'b0 : (randMode ? 1'($urandom_range(0, 1)) : 1'b1);
            txReady     = randMode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // TX monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prevStall = 1'b0;
            end else begin
                if (txMetaValid && txMetaReady) begin
                    chkTrue("tx_meta_expected", expMetaQ.size() != 0);
                    if (expMetaQ.size() != 0) chk("tx_meta", txMetaData, expMetaQ.pop_front());
                    chk("tx_meta_keep", txMetaKeep, 10'h3FF);
                    chk("tx_meta_last", txMetaLast, 1'b1);
                end
                if (prevStall) chk("tx_hold", {txValid, txData, txKeep, txLast}, prevBeat);
                if (txValid && txReady) begin
                    chkTrue("tx_beat_expected", expQ.size() != 0);
                    if (expQ.size() != 0) chk("tx_beat", {txData, txKeep, txLast}, expQ.pop_front());
                    lastTxKeep = txKeep;
                    lastTxLast = txLast;
                end
                prevStall = txValid && !txReady;
                prevBeat  = {txValid, txData, txKeep, txLast};
            end
        end
    end

    // -------------------------------------------------------- driver tasks
    // All tasks are entered and left 1 ns after a rising edge.
    task automatic sendMeta(input logic [79:0] m);
        bit ok;
        ok          = 1'b0;
        rxMetaValid = 1'b1;
        rxMetaData  = m;
        rxMetaKeep  = 10'($urandom);
        rxMetaLast  = 1'($urandom);
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            if (rxMetaReady) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        rxMetaValid = 1'b0;
        if (!ok) chkTrue("rx_meta_timeout", ok);
    endtask

    task automatic sendBeats(input int n, input logic [7:0] lastKeep, input bit withLast,
                             input int maxGap);
        bit ok;
        bit isLast;
        int gap;
        for (int b = 0; b < n; b++) begin
            gap = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            ok      = 1'b0;
            isLast  = withLast && (b == n - 1);
            rxData  = {$urandom, $urandom};
            rxKeep  = isLast ? lastKeep : 8'hFF;
            rxLast  = isLast;
            rxValid = 1'b1;
            for (int i = 0; i < TMO && !ok; i++) begin
                @(negedge clk);
                if (rxReady) ok = 1'b1;
            end
            if (!ok) begin
                chkTrue("rx_beat_timeout", ok);
                rxValid = 1'b0;
                return;
            end
            expQ.push_back({rxData, rxKeep, rxLast});
            accCnt++;
            @(posedge clk);
            #1;
            rxValid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < TMO && (expQ.size() != 0 || expMetaQ.size() != 0); i++) begin
            @(posedge clk);
        end
        chk("drain_beats", expQ.size(), 0);
        chk("drain_meta", expMetaQ.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_tx_valid", txValid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------- main steps
    logic [79:0] m;
    logic [7:0]  k;

    initial begin
        en          = 1'b1;
        rank        = 32'h0000_0001;
        rxMetaData  = '0;
        rxMetaValid = 1'b0;
        rxMetaKeep  = '0;
        rxMetaLast  = 1'b0;
        rxData      = '0;
        rxKeep      = '0;
        rxValid     = 1'b0;
        rxLast      = 1'b0;

        // Reset: everything quiet even with an offered meta and enable high.
        rxMetaValid = 1'b1;
        rxValid     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_meta_ready", rxMetaReady, 1'b0);
        chk("rst_data_ready", rxReady, 1'b0);
        chk("rst_meta_valid", txMetaValid, 1'b0);
        chk("rst_data_valid", txValid, 1'b0);
        chk("rst_meta_data", txMetaData, 80'h0);
        chk("rst_data", txData, 64'h0);
        chk("rst_keep", txKeep, 8'h0);
        chk("rx_ports", rxPorts, 32'h0000_0001);
        @(posedge clk);
        #1;
        rxMetaValid = 1'b0;
        rxValid     = 1'b0;
        rstN        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_meta_ready", rxMetaReady, 1'b1);
        @(posedge clk);
        #1;

        // Single datagram with fixed fields and latency checks.
        expMetaQ.push_back(80'h0000_0010_2263_01_2710_03);
        sendMeta(80'h0000_0010_2710_03_2263_01);
        @(negedge clk);
        chk("meta_lat_c1", txMetaValid, 1'b0);
        @(negedge clk);
        chk("meta_lat_c2", txMetaValid, 1'b1);
        @(posedge clk);
        #1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        sendBeats(1, 8'hFF, 1'b0, 0);
        @(negedge clk);
        chk("data_lat_c1", txValid, 1'b0);
        @(negedge clk);
        chk("data_lat_c2", txValid, 1'b1);
        @(posedge clk);
        #1;
        sendBeats(1, 8'hFF, 1'b1, 0);
        dgDone++;
        waitDrain();
        chk("single_last_keep", lastTxKeep, 8'hFF);
        chk("single_last_last", lastTxLast, 1'b1);

        // Back-pressure: TX meta held off, 24 beats into a 16-deep FIFO.
        metaHold = 1'b1;
        rank     = $urandom;
        m        = {16'($urandom), $urandom, $urandom};
        expMetaQ.push_back(expEcho(m, rank));
        accCnt   = 0;
        sendMeta(m);
        fork
            sendBeats(24, 8'hFF, 1'b1, 0);
            begin
                repeat (30) @(negedge clk);
                chk("bp_accepted", accCnt, 16);
                chk("bp_rx_ready", rxReady, 1'b0);
                chk("bp_meta_held", txMetaValid, 1'b1);
                metaHold = 1'b0;
            end
        join
        dgDone++;
        waitDrain();
        chk("bp_all_beats", accCnt, 24);

        // Partial keep on the final beat.
        rank = $urandom;
        m    = {16'($urandom), $urandom, $urandom};
        expMetaQ.push_back(expEcho(m, rank));
        sendMeta(m);
        sendBeats(3, 8'h0F, 1'b1, 0);
        dgDone++;
        waitDrain();
        chk("pk_last_keep", lastTxKeep, 8'h0F);
        chk("pk_last_last", lastTxLast, 1'b1);

        // Enable low before meta: meta is never taken.
        en          = 1'b0;
        rxMetaValid = 1'b1;
        rxMetaData  = {16'($urandom), $urandom, $urandom};
        repeat (6) begin
            @(negedge clk);
            chk("en_low_meta_ready", rxMetaReady, 1'b0);
        end
        chk("en_low_no_tx_meta", txMetaValid, 1'b0);
        @(posedge clk);
        #1;
        rxMetaValid = 1'b0;

        // Enable dropped mid-datagram: datagram finishes, next meta refused.
        en   = 1'b1;
        rank = $urandom;
        m    = {16'($urandom), $urandom, $urandom};
        expMetaQ.push_back(expEcho(m, rank));
        sendMeta(m);
        sendBeats(2, 8'hFF, 1'b0, 1);
        en = 1'b0;
        sendBeats(4, 8'h3F, 1'b1, 1);
        dgDone++;
        waitDrain();
        rxMetaValid = 1'b1;
        repeat (8) @(negedge clk);
        chk("en_mid_meta_refused", rxMetaReady, 1'b0);
        chk("en_mid_no_tx_meta", txMetaValid, 1'b0);
        @(posedge clk);
        #1;
        rxMetaValid = 1'b0;
        en          = 1'b1;

        // Reset after 3 of 8 beats: immediate clear, then a clean datagram.
        rank = $urandom;
        m    = {16'($urandom), $urandom, $urandom};
        expMetaQ.push_back(expEcho(m, rank));
        sendMeta(m);
        sendBeats(3, 8'hFF, 1'b0, 0);
        rxValid = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        chk("rstmid_meta_ready", rxMetaReady, 1'b0);
        chk("rstmid_data_ready", rxReady, 1'b0);
        chk("rstmid_meta_valid", txMetaValid, 1'b0);
        chk("rstmid_data_valid", txValid, 1'b0);
        rxValid = 1'b0;
        expQ.delete();
        expMetaQ.delete();
        dgDone = 0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        rank = $urandom;
        m    = {16'($urandom), $urandom, $urandom};
        expMetaQ.push_back(expEcho(m, rank));
        sendMeta(m);
        sendBeats(5, 8'h81, 1'b1, 0);
        dgDone++;
        waitDrain();

        // Randomized datagrams with random gaps and TX back-pressure.
        randMode = 1'b1;
        for (int d = 0; d < 6; d++) begin
            rank = $urandom;
            m    = {16'($urandom), $urandom, $urandom};
            k    = 8'($urandom_range(1, 255));
            expMetaQ.push_back(expEcho(m, rank));
            sendMeta(m);
            sendBeats($urandom_range(1, 20), k, 1'b1, 2);
            dgDone++;
            waitDrain();
            chk("rand_last_keep", lastTxKeep, k);
        end
        randMode = 1'b0;

`ifdef UDP_ECHO_STATS_EN
        chk("stats", echoStats, {dgDone[15:0], dgDone[15:0]});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
